// File: rtl/peltier_regulator.sv
// Peltier temperature regulator: periodically samples an MCP3008 through a
// request/accept handshake and runs a clamped PI loop to produce a PWM duty.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for the sample-period tick
// TRIG1    | conversion request, first cycle
// TRIG2    | conversion request, second cycle
// WAIT     | waiting for mcp_avail, timeout timer running
// ACCEPT   | consume result, latch last_code
// CALC_P   | error and proportional term
// CALC_I   | integrator update with anti-windup clamp
// CALC_OUT | combine terms, register duty
module peltier_regulator #(
    parameter int SAMPLE_PERIOD = 1000000,
    parameter int TIMEOUT       = 4096,
    parameter int PSHIFT        = 4,
    parameter int ISHIFT        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [9:0]  setpoint,
    input  logic [7:0]  kp,
    input  logic [7:0]  ki,
    input  logic        mcp_busy,
    output logic        mcp_sample,
    input  logic [15:0] mcp_data,
    input  logic        mcp_avail,
    output logic        mcp_accept,
    output logic [7:0]  duty,
    output logic [9:0]  last_code,
    output logic        fault
);

    localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic signed [20:0] I_MAX = 21'(255) <<< ISHIFT;

    typedef enum logic [2:0] {
        IDLE, TRIG1, TRIG2, WAIT, ACCEPT, CALC_P, CALC_I, CALC_OUT
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0]      period_cnt;
    logic               tick;
    logic [TW-1:0]      tmo_cnt;
    logic               tmo_done;
    logic               enable_d;
    logic signed [10:0] err, err_nxt;
    logic signed [18:0] p_term, p_nxt, p_sh;
    logic signed [19:0] integ, i_inc, i_sh;
    logic signed [20:0] integ_sum, out_sum;
    logic               unused_data;

    assign unused_data = ^mcp_data[15:10];
    assign tick        = (period_cnt == PW'(SAMPLE_PERIOD - 1));
    assign tmo_done    = (tmo_cnt == '0);

    // Datapath arithmetic, all sign-extended so no intermediate can overflow.
    assign err_nxt   = $signed({1'b0, last_code}) - $signed({1'b0, setpoint});
    assign p_nxt     = $signed({{8{err_nxt[10]}}, err_nxt}) * $signed({11'b0, kp});
    assign i_inc     = $signed({{9{err[10]}}, err}) * $signed({12'b0, ki});
    assign integ_sum = $signed({integ[19], integ}) + $signed({i_inc[19], i_inc});
    assign p_sh      = p_term >>> PSHIFT;
    assign i_sh      = integ >>> ISHIFT;
    assign out_sum   = $signed({{2{p_sh[18]}}, p_sh}) + $signed({i_sh[19], i_sh});

    always_ff @(posedge clk) begin
        if (rst || tick) period_cnt <= '0;
        else             period_cnt <= period_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || state != WAIT) tmo_cnt <= TW'(TIMEOUT - 1);
        else if (!tmo_done)       tmo_cnt <= tmo_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:     if (tick && !mcp_busy) state_nxt = TRIG1;
                TRIG1:    state_nxt = TRIG2;
                TRIG2:    state_nxt = WAIT;
                WAIT: begin
                    if (mcp_avail)     state_nxt = ACCEPT;
                    else if (tmo_done) state_nxt = IDLE;
                end
                ACCEPT:   state_nxt = CALC_P;
                CALC_P:   state_nxt = CALC_I;
                CALC_I:   state_nxt = CALC_OUT;
                CALC_OUT: state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        mcp_sample = 1'b0;
        mcp_accept = 1'b0;
        if (enable && (state == TRIG1 || state == TRIG2)) mcp_sample = 1'b1;
        if (state == ACCEPT)                              mcp_accept = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_d  <= 1'b0;
            duty      <= '0;
            last_code <= '0;
            fault     <= 1'b0;
            err       <= '0;
            p_term    <= '0;
            integ     <= '0;
        end else begin
            enable_d <= enable;
            if (enable_d && !enable) fault <= 1'b0;
            if (!enable) begin
                duty  <= '0;
                integ <= '0;
            end else begin
                unique case (state)
                    WAIT: begin
                        if (!mcp_avail && tmo_done) begin
                            fault <= 1'b1;
                            duty  <= '0;
                        end
                    end
                    ACCEPT: last_code <= mcp_data[9:0];
                    CALC_P: begin
                        err    <= err_nxt;
                        p_term <= p_nxt;
                    end
                    CALC_I: begin
                        if (integ_sum < 0)          integ <= '0;
                        else if (integ_sum > I_MAX) integ <= 20'(I_MAX);
                        else                        integ <= integ_sum[19:0];
                    end
                    CALC_OUT: begin
                        if (out_sum < 0)                      duty <= '0;
                        else if (out_sum > 21'sd255)          duty <= 8'd255;
                        else                                  duty <= out_sum[7:0];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_peltier_regulator.sv
// Directed bench for peltier_regulator: drives an ADC handshake by hand and
// compares duty, last_code, fault and handshake timing to hand-computed values.
module tb_peltier_regulator;

    localparam int SAMPLE_PERIOD = 64;
    localparam int TIMEOUT       = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [9:0]  setpoint = '0;
    logic [7:0]  kp = '0;
    logic [7:0]  ki = '0;
    logic        mcp_busy = 1'b0;
    logic        mcp_sample;
    logic [15:0] mcp_data = '0;
    logic        mcp_avail = 1'b0;
    logic        mcp_accept;
    logic [7:0]  duty;
    logic [9:0]  last_code;
    logic        fault;

    int n_vec = 0;
    int n_err = 0;
    int exp_duty = 0;

    peltier_regulator #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD),
        .TIMEOUT(TIMEOUT),
        .PSHIFT(4),
        .ISHIFT(8)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .setpoint(setpoint),
        .kp(kp), .ki(ki), .mcp_busy(mcp_busy), .mcp_sample(mcp_sample),
        .mcp_data(mcp_data), .mcp_avail(mcp_avail), .mcp_accept(mcp_accept),
        .duty(duty), .last_code(last_code), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int want);
        n_vec++;
        if (obs != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, want);
        end
    endtask

    task automatic wait_sample(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * SAMPLE_PERIOD; i++) begin
            @(negedge clk);
            if (mcp_sample) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("sample_seen", 0, 1);
    endtask

    // One full conversion; want is the duty expected four cycles after accept.
    task automatic do_sample(input logic [9:0] code, input int want);
        bit ok;
        bit got;
        int w;
        wait_sample(ok);
        if (!ok) return;
        w = 0;
        while (mcp_sample && w < 8) begin
            w++;
            @(negedge clk);
        end
        chk("sample_width", w, 2);
        mcp_avail = 1'b1;
        mcp_data  = {6'h2a, code};
        got = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (mcp_accept) begin
                got = 1'b1;
                break;
            end
        end
        mcp_avail = 1'b0;
        if (!got) begin
            chk("accept_seen", 0, 1);
            return;
        end
        @(negedge clk);
        chk("accept_width", int'(mcp_accept), 0);
        @(negedge clk);
        @(negedge clk);
        chk("duty_hold", int'(duty), exp_duty);
        @(negedge clk);
        chk("duty", int'(duty), want);
        chk("last_code", int'(last_code), int'(code));
        exp_duty = want;
    endtask

    task automatic toggle_enable();
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        exp_duty = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bit any;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_duty", int'(duty), 0);
        chk("rst_last_code", int'(last_code), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_sample", int'(mcp_sample), 0);
        chk("rst_accept", int'(mcp_accept), 0);

        // A tick that lands while the ADC is busy is dropped.
        mcp_busy = 1'b1;
        any = 1'b0;
        repeat (SAMPLE_PERIOD + 6) begin
            @(negedge clk);
            if (mcp_sample) any = 1'b1;
        end
        mcp_busy = 1'b0;
        chk("busy_drop", int'(any), 0);

        // Proportional step then integrator build-up: integ 80,160,240,320.
        setpoint = 10'd500; kp = 8'd16; ki = 8'd4;
        do_sample(10'd520, 20);
        do_sample(10'd520, 20);
        do_sample(10'd520, 20);
        do_sample(10'd520, 21);

        // Saturation; integ clamps at 65280 so a -300 nudge lands on 253.
        setpoint = 10'd0; kp = 8'd255; ki = 8'd255;
        do_sample(10'd1023, 255);
        setpoint = 10'd300; kp = 8'd0; ki = 8'd1;
        do_sample(10'd0, 253);

        // Negative error after a clear: duty 0, integrator held at 0.
        toggle_enable();
        chk("disable_duty", int'(duty), 0);
        setpoint = 10'd500; kp = 8'd16; ki = 8'd4;
        do_sample(10'd400, 0);
        do_sample(10'd520, 20);

        // Timeout: fault exactly TIMEOUT cycles after entering WAIT.
        wait_sample(ok);
        if (ok) begin
            @(negedge clk);
            @(negedge clk);
            repeat (TIMEOUT - 1) @(negedge clk);
            chk("tmo_early_fault", int'(fault), 0);
            chk("tmo_early_duty", int'(duty), 20);
            @(negedge clk);
            chk("tmo_fault", int'(fault), 1);
            chk("tmo_duty", int'(duty), 0);
            exp_duty = 0;
            repeat (5) @(negedge clk);
            chk("fault_sticky", int'(fault), 1);
        end
        toggle_enable();
        chk("fault_clear", int'(fault), 0);

        // Disable mid-WAIT: later mcp_avail is ignored.
        do_sample(10'd520, 20);
        wait_sample(ok);
        if (ok) begin
            @(negedge clk);
            @(negedge clk);
            enable = 1'b0;
            @(negedge clk);
            mcp_avail = 1'b1;
            mcp_data  = 16'd777;
            any = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (mcp_accept) any = 1'b1;
            end
            chk("dis_accept", int'(any), 0);
            chk("dis_duty", int'(duty), 0);
            chk("dis_last_code", int'(last_code), 520);
            mcp_avail = 1'b0;
        end
        enable = 1'b1;
        exp_duty = 0;
        @(negedge clk);

        // Reset mid-WAIT with a result pending.
        do_sample(10'd520, 20);
        wait_sample(ok);
        if (ok) begin
            @(negedge clk);
            @(negedge clk);
            mcp_avail = 1'b1;
            mcp_data  = 16'd777;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            any = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (mcp_accept) any = 1'b1;
            end
            chk("rst_wait_accept", int'(any), 0);
            chk("rst_wait_duty", int'(duty), 0);
            chk("rst_wait_last_code", int'(last_code), 0);
            chk("rst_wait_fault", int'(fault), 0);
            mcp_avail = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/peltier_regulator.md
PELTIER_REGULATOR -- requirements
Module: peltier_regulator

Interface
REQ-001 Parameter SAMPLE_PERIOD, default 1000000; clk cycles between conversion requests (10 ms at 100 MHz).
REQ-002 Parameter TIMEOUT, default 4096; clk cycles to wait for mcp_avail before declaring a fault.
REQ-003 Parameter PSHIFT, default 4; right-shift applied to the proportional term.
REQ-004 Parameter ISHIFT, default 8; right-shift applied to the integrator.
REQ-005 Clocking: one clock, clk; reset rst is synchronous and active-high.
REQ-006 clk  in  1  system clock, 100 MHz.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 enable  in  1  regulation on; low forces duty 0 and clears the integrator.
REQ-009 setpoint  in  10  target MCP3008 code.
REQ-010 kp  in  8  unsigned proportional gain.
REQ-011 ki  in  8  unsigned integral gain.
REQ-012 mcp_busy  in  1  ADC interface busy.
REQ-013 mcp_sample  out  1  conversion request to the ADC interface, which samples on the rising edge.
REQ-014 mcp_data  in  16  ADC result; bits [9:0] are the code, bits [15:10] are ignored.
REQ-015 mcp_avail  in  1  result valid.
REQ-016 mcp_accept  out  1  result consumed.
REQ-017 duty  out  8  Peltier PWM duty cycle.
REQ-018 last_code  out  10  most recent accepted code.
REQ-019 fault  out  1  sticky flag: conversion timed out.

Function
REQ-020 States: IDLE, TRIG1, TRIG2, WAIT, ACCEPT, CALC_P, CALC_I, CALC_OUT.
REQ-021 A period counter runs in every state; on reaching SAMPLE_PERIOD-1 it wraps to 0 and raises a one-cycle tick.
REQ-022 IDLE -> TRIG1 on tick when enable=1 and mcp_busy=0; a tick missed because mcp_busy=1 is dropped, not queued.
REQ-023 mcp_sample = 1 in TRIG1 and TRIG2 only (2-cycle pulse), then the FSM enters WAIT.
REQ-024 WAIT -> ACCEPT when mcp_avail=1; mcp_accept = 1 for exactly one cycle, in ACCEPT.
REQ-025 In ACCEPT, last_code <= mcp_data[9:0].
REQ-026 WAIT timeout: TIMEOUT cycles without mcp_avail sets fault=1, forces duty=0 and returns the FSM to IDLE.
REQ-027 fault clears only on rst or on an enable falling edge.
REQ-028 CALC_P: err = last_code - setpoint, 11-bit signed; p = err * kp, 19-bit signed.
REQ-029 CALC_I: integ <= clamp(integ + err*ki, 0, 255<<ISHIFT); integ is 20-bit signed; clamping provides anti-windup.
REQ-030 CALC_OUT: sum = (p >>> PSHIFT) + (integ >>> ISHIFT); duty <= clamp(sum, 0, 255); then IDLE.
REQ-031 Accept-to-duty-update latency is 4 cycles: ACCEPT, CALC_P, CALC_I, CALC_OUT, with duty registered at the end of CALC_OUT.
REQ-032 duty holds its value between updates.
REQ-033 enable=0 in any state: FSM -> IDLE next cycle, duty <= 0, integ <= 0, mcp_sample=0.
REQ-034 If enable falls during WAIT, the next mcp_avail is not accepted.
REQ-035 Setpoint or gain changes take effect at the next CALC_P; no mid-calculation update.
REQ-036 duty never changes except in CALC_OUT, on timeout, on disable, or on rst.

Reset
REQ-037 rst=1 sets: state=IDLE, period counter=0, integ=0, duty=0, last_code=0, fault=0, mcp_sample=0, mcp_accept=0.
REQ-038 rst takes priority over enable and over every in-flight handshake; a result pending at reset is not accepted.

Verification
REQ-039 Proportional step: setpoint=500, code=520, kp=16, ki=4 -> duty=20 four cycles after accept, integ=80.
REQ-040 Integrator: the same stimulus repeated -> after 4 samples integ=320, duty=21.
REQ-041 Saturation: setpoint=0, code=1023, kp=255, ki=255 -> duty=255; integ clamps at 65280.
REQ-042 Negative error: setpoint=500, code=400, kp=16 -> duty=0, integ stays 0.
REQ-043 Timeout: mcp_avail held low -> fault=1 and duty=0 exactly TIMEOUT cycles after entering WAIT; an enable toggle clears fault.
REQ-044 Disable or reset mid-WAIT: a later mcp_avail pulse gives mcp_accept=0, duty=0 and an unchanged last_code.
